// File: rtl/gshare_predictor.sv
// gshare_predictor: global-history branch direction predictor with PHT training and GHR repair
module gshare_predictor #(
  parameter int GHR_BITS = 8,
  parameter int CNT_BITS = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                predict_valid,
  input  logic [31:0]         predict_PC,
  output logic                pred_taken,
  output logic [GHR_BITS-1:0] pred_idx,
  output logic [GHR_BITS-1:0] pred_ghr,
  input  logic                resolve_valid,
  input  logic                resolve_taken,
  input  logic [GHR_BITS-1:0] resolve_idx,
  input  logic [GHR_BITS-1:0] resolve_ghr,
  input  logic                restore_valid,
  output logic [GHR_BITS-1:0] ghr_out,
  output logic [CNT_BITS-1:0] num_resolved,
  output logic [CNT_BITS-1:0] num_mispred
);
  localparam int N = 1 << GHR_BITS;
  logic [1:0]          pht [N];
  logic [GHR_BITS-1:0] ghr, idx;
  logic [1:0]          cnt, cnt_nx;
  logic                taken;
  // lookup reads the pre-edge table, so a same-cycle training write is not visible yet
  always_comb begin
    idx        = predict_PC[GHR_BITS+1:2] ^ ghr;
    taken      = pht[idx][1];
    pred_taken = reset ? 1'b0 : taken;
    pred_idx   = reset ? '0 : idx;
    pred_ghr   = reset ? '0 : ghr;
    ghr_out    = ghr;
    cnt        = pht[resolve_idx];
    cnt_nx     = resolve_taken ? ((cnt == 2'd3) ? cnt : cnt + 2'd1)
                               : ((cnt == 2'd0) ? cnt : cnt - 2'd1);
  end
  // training, history update (restore beats speculation) and statistics
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N; i++) pht[i] <= 2'b01;
      ghr          <= '0;
      num_resolved <= '0;
      num_mispred  <= '0;
    end else begin
      if (resolve_valid) pht[resolve_idx] <= cnt_nx;
      ghr <= restore_valid ? (resolve_valid ? {resolve_ghr[GHR_BITS-2:0], resolve_taken} : resolve_ghr)
           : predict_valid ? {ghr[GHR_BITS-2:0], taken} : ghr;
      num_resolved <= num_resolved + {{(CNT_BITS-1){1'b0}}, resolve_valid};
      num_mispred  <= num_mispred + {{(CNT_BITS-1){1'b0}}, resolve_valid & restore_valid};
    end
  end
endmodule

// File: tb/tb_gshare_predictor.sv
// tb_gshare_predictor: directed checks of prediction, training, history and restore
module tb_gshare_predictor;
  logic        clock = 0, reset = 1;
  logic        predict_valid = 0, resolve_valid = 0, resolve_taken = 0, restore_valid = 0;
  logic [31:0] predict_PC = 0;
  logic [7:0]  resolve_idx = 0, resolve_ghr = 0;
  logic        pred_taken;
  logic [7:0]  pred_idx, pred_ghr, ghr_out;
  logic [31:0] num_resolved, num_mispred;
  int checks = 0, errors = 0;
  gshare_predictor dut (
    .clock(clock), .reset(reset), .predict_valid(predict_valid), .predict_PC(predict_PC),
    .pred_taken(pred_taken), .pred_idx(pred_idx), .pred_ghr(pred_ghr),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken), .resolve_idx(resolve_idx),
    .resolve_ghr(resolve_ghr), .restore_valid(restore_valid), .ghr_out(ghr_out),
    .num_resolved(num_resolved), .num_mispred(num_mispred)
  );
  always #5 clock = ~clock;
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic train(input logic [7:0] i, input logic t, input int n);
    resolve_valid = 1; resolve_idx = i; resolve_taken = t;
    repeat (n) tick();
    resolve_valid = 0;
  endtask
  initial begin
    logic [7:0] gh [4];
    gh = '{8'h00, 8'h01, 8'h03, 8'h07};
    predict_valid = 1; predict_PC = 32'h100;
    tick(); tick();
    chk("rst_taken", pred_taken, 0);
    chk("rst_idx", pred_idx, 0);
    chk("rst_ghr", pred_ghr, 0);
    chk("rst_cnt", num_resolved, 0);
    reset = 0; #1;
    chk("p0_taken", pred_taken, 0);
    chk("p0_idx", pred_idx, 8'h40);
    chk("p0_ghr", pred_ghr, 0);
    tick();
    chk("p0_ghr_out", ghr_out, 0);
    predict_valid = 0;
    train(8'h40, 1, 3);
    predict_valid = 1; #1;
    chk("sat_taken", pred_taken, 1);
    predict_valid = 0;
    train(8'h40, 0, 1); #1;
    chk("dec1_taken", pred_taken, 1);
    train(8'h40, 0, 1); #1;
    chk("dec2_taken", pred_taken, 0);
    chk("train_res", num_resolved, 5);
    chk("train_mis", num_mispred, 0);
    train(8'h40, 1, 2);
    train(8'h41, 1, 2);
    train(8'h43, 1, 2);
    train(8'h47, 1, 2);
    predict_valid = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("hist_pghr", pred_ghr, gh[k]);
      chk("hist_taken", pred_taken, 1);
      tick();
      chk("hist_ghr", ghr_out, {gh[k][6:0], 1'b1});
    end
    predict_valid = 0;
    restore_valid = 1; resolve_ghr = 8'h5A;
    tick();
    chk("set5a", ghr_out, 8'h5A);
    predict_valid = 1; resolve_valid = 1; resolve_taken = 1; resolve_idx = 8'h00; resolve_ghr = 8'h12;
    tick();
    chk("mis_ghr", ghr_out, 8'h25);
    chk("mis_res", num_resolved, 14);
    chk("mis_mis", num_mispred, 1);
    predict_valid = 0; resolve_valid = 0; resolve_ghr = 8'h33;
    tick();
    restore_valid = 0;
    chk("jmp_ghr", ghr_out, 8'h33);
    chk("jmp_res", num_resolved, 14);
    chk("jmp_mis", num_mispred, 1);
    predict_PC = 32'h1CC; #1;
    chk("jmp_idx", pred_idx, 8'h40);
    chk("jmp_pht", pred_taken, 1);
    predict_PC = 32'h0;
    resolve_valid = 1; resolve_idx = 8'h33; resolve_taken = 1; #1;
    chk("col_idx", pred_idx, 8'h33);
    chk("col_old", pred_taken, 0);
    tick();
    resolve_valid = 0; #1;
    chk("col_new", pred_taken, 1);
    reset = 1; resolve_valid = 1; resolve_idx = 8'h40; resolve_taken = 0;
    tick();
    reset = 0; resolve_valid = 0; #1;
    chk("mrst_ghr", ghr_out, 0);
    chk("mrst_res", num_resolved, 0);
    chk("mrst_mis", num_mispred, 0);
    predict_PC = 32'h100; #1;
    chk("mrst_p40", pred_taken, 0);
    predict_PC = 32'hCC; #1;
    chk("mrst_p33", pred_taken, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/gshare_predictor.md
Name: gshare_predictor

Overview:
- Global-history (gshare) conditional-branch direction predictor between fetch and the branch stack.
- Each cycle it predicts one fetched conditional branch and speculatively shifts the global history register (GHR).
- It returns a prediction snapshot (PHT index, GHR) that travels with the branch into its branch stack entry.
- When the branch stack resolves a branch, the block trains the pattern history table (PHT). On a restore it repairs the GHR from the snapshot.

Parameters:
- GHR_BITS, 8, global history length; the PHT has 2^GHR_BITS entries.
- CNT_BITS, 32, width of the performance counters.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- predict_valid  in  1  fetch presents a conditional branch this cycle
- predict_PC  in  32  PC of that branch
- pred_taken  out  1  predicted direction
- pred_idx  out  GHR_BITS  PHT index used; stored in the branch stack entry
- pred_ghr  out  GHR_BITS  GHR value before this prediction; stored in the branch stack entry
- resolve_valid  in  1  a conditional branch (not a jump) is resolving this cycle
- resolve_taken  in  1  actual direction of the resolving branch
- resolve_idx  in  GHR_BITS  pred_idx snapshot of the resolving branch
- resolve_ghr  in  GHR_BITS  pred_ghr snapshot of the resolving branch
- restore_valid  in  1  branch stack is squashing and redirecting this cycle
- ghr_out  out  GHR_BITS  current GHR (debug)
- num_resolved  out  CNT_BITS  conditional branches resolved since reset
- num_mispred  out  CNT_BITS  resolved conditional branches with restore_valid asserted

Behaviour:
- Reset (synchronous, active-high):
  - every PHT counter becomes 2'b01 (weakly not-taken);
  - GHR, num_resolved and num_mispred become 0;
  - pred_taken, pred_idx and pred_ghr are 0 while reset is high.
  - Reset asserted mid-operation discards all state on that edge, including any pending training.
- Prediction is combinational, with zero-cycle latency:
  - idx = predict_PC[GHR_BITS+1:2] XOR GHR;
  - pred_taken = PHT[idx][1], pred_idx = idx, pred_ghr = GHR.
  - Outputs are computed even when predict_valid=0; fetch ignores them in that case.
- Speculative GHR update at posedge, when predict_valid=1 and restore_valid=0: GHR <= {GHR[GHR_BITS-2:0], pred_taken}.
- Training at posedge, when resolve_valid=1: PHT[resolve_idx] is updated as a 2-bit saturating counter.
  - Increment if resolve_taken=1, decrement otherwise.
  - The counter saturates at 3 and at 0.
  - Training applies whether or not restore_valid is asserted.
- GHR repair at posedge, when restore_valid=1:
  - if resolve_valid=1: GHR <= {resolve_ghr[GHR_BITS-2:0], resolve_taken};
  - if resolve_valid=0 (jump target mispredict): GHR <= resolve_ghr.
  - Restore has priority over the speculative update; a same-cycle prediction does not shift the GHR because fetch is being redirected.
- Read/write collision: a prediction reading PHT[x] in the same cycle that training writes PHT[x] sees the old value. The new value is visible from the next cycle.
- Counters:
  - num_resolved increments on each cycle with resolve_valid=1.
  - num_mispred increments when resolve_valid=1 and restore_valid=1.
  - Both wrap modulo 2^CNT_BITS.
- At most one resolve per cycle; the branch stack guarantees this.
- No stall or backpressure: the block accepts every cycle.
- GHR wrap: the shift discards the MSB; there is no other boundary case.

Test Plan:
- Reset state: hold reset 2 cycles, then predict_valid=1, PC=0x100 → pred_taken=0, pred_idx=0x40, pred_ghr=0x00. Next cycle ghr_out=0x00 (predicted not-taken shifted in).
- Training and saturation: resolve idx 0x40 taken 3 times with restore_valid=0, then predict PC=0x100 with GHR=0 → pred_taken=1. Resolve 0x40 not-taken once → still taken (counter 3→2). Not-taken again → not-taken (counter 1).
- Speculative history: make PHT[idx] strongly taken for 4 consecutive predictions with GHR starting at 0x00 → ghr_out follows 0x01, 0x03, 0x07, 0x0F, and pred_ghr reports the pre-shift value each cycle.
- Branch mispredict restore: GHR=0x5A; restore_valid=1, resolve_valid=1, resolve_ghr=0x12, resolve_taken=1, with predict_valid=1 the same cycle → ghr_out=0x25 next cycle, num_mispred increments by 1, num_resolved increments by 1.
- Jump restore: restore_valid=1, resolve_valid=0, resolve_ghr=0x33 → ghr_out=0x33; no PHT change; both counters unchanged.
- Collision and mid-run reset: train idx X taken while predicting at idx X with counter=1 → same-cycle pred_taken=0, next-cycle pred_taken=1. Then assert reset with resolve_valid=1 → PHT back to 01, ghr_out=0, counters=0.
